// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator sequencer front-end:
// door FSM states, door output bundle, call-bit positions and the stopped test.
package elevator_pkg;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_FORCE = 2'd1,
    D_DWELL = 2'd2,
    D_CLOSE = 2'd3
  } door_state_e;

  typedef struct packed {
    logic open_door;
    logic close_door;
    logic dwell;
  } door_out_t;

  localparam int NUM_CALLS = 10;

  // Bit positions of {C1U,C2D,C2U,C3D,C3U,C4D,G1,G2,G3,G4}, MSB first.
  localparam int C1U_IDX = 9;
  localparam int C2D_IDX = 8;
  localparam int C2U_IDX = 7;
  localparam int C3D_IDX = 6;
  localparam int C3U_IDX = 5;
  localparam int C4D_IDX = 4;
  localparam int G1_IDX  = 3;
  localparam int G2_IDX  = 2;
  localparam int G3_IDX  = 1;
  localparam int G4_IDX  = 0;

  // floorControl encodes stopped states with an even code.
  function automatic logic is_stopped(input logic [2:0] s);
    return (s & 3'b001) == 3'b000;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Enable-gated saturating cycle counter. done is combinational: high while
// enabled, not restarting, and sitting on the terminal count TC-1.
module cycle_timer #(
  parameter int unsigned TC    = 2,
  parameter int          CNT_W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic done
);

  localparam logic [CNT_W-1:0] TC_M1 = CNT_W'(TC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_tc;

  assign at_tc = (cnt_q == TC_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || restart) cnt_d = '0;
    else if (!at_tc)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = en & ~restart & at_tc;

endmodule

// File: rtl/elevator_sequencer.sv
// Call latch, door dwell FSM and travel timer in front of floorControl.
// Define DOOR_NUDGE_EN to force a close after a long continuous sensor block.
module elevator_sequencer
  import elevator_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 200_000_000,
  parameter int unsigned MOVE_CYCLES  = 300_000_000,
  parameter int unsigned NUDGE_CYCLES = 1_000_000_000,
  parameter int          CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CALLS-1:0] btn,
  input  logic [NUM_CALLS-1:0] resetButtons,
  input  logic [2:0]           state,
  input  logic                 door,
  input  logic                 MoveCountEn,
  input  logic                 doorSensor,
  input  logic                 doorOpenBtn,
  input  logic                 doorCloseBtn,
  output logic [NUM_CALLS-1:0] calls,
  output logic                 openDoor,
  output logic                 closeDoor,
  output logic                 MoveCountDone,
  output logic                 dwellActive
);

  // Call latch: clear beats a coincident press.
  logic [NUM_CALLS-1:0] calls_q, calls_d;

  always_comb calls_d = (calls_q | btn) & ~resetButtons;

  always_ff @(posedge clk) begin
    if (reset) calls_q <= '0;
    else       calls_q <= calls_d;
  end

  assign calls = calls_q;

  // Travel timer, independent of the door FSM.
  logic move_hit, move_done_q, move_done_d;

  cycle_timer #(.TC(MOVE_CYCLES), .CNT_W(CNT_W)) u_move (
    .clk     (clk),
    .reset   (reset),
    .en      (MoveCountEn),
    .restart (1'b0),
    .done    (move_hit)
  );

  always_comb move_done_d = move_hit;

  always_ff @(posedge clk) begin
    if (reset) move_done_q <= 1'b0;
    else       move_done_q <= move_done_d;
  end

  assign MoveCountDone = move_done_q;

  // Door FSM
  door_state_e dst_q, dst_d;
  door_out_t   dout_q, dout_d;
  logic        stopped, sensor_eff, act, dwell_done, nudge_done;

  assign stopped = is_stopped(state);
  assign act     = sensor_eff | doorOpenBtn;

`ifdef DOOR_NUDGE_EN
  logic nudge_q, nudge_d, nudge_en;

  assign nudge_en = door & ((dst_q == D_DWELL) | (dst_q == D_CLOSE)) & doorSensor & ~nudge_q;

  cycle_timer #(.TC(NUDGE_CYCLES), .CNT_W(CNT_W)) u_nudge (
    .clk     (clk),
    .reset   (reset),
    .en      (nudge_en),
    .restart (1'b0),
    .done    (nudge_done)
  );

  always_comb begin
    nudge_d = nudge_q;
    if (!door)           nudge_d = 1'b0;
    else if (nudge_done) nudge_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) nudge_q <= 1'b0;
    else       nudge_q <= nudge_d;
  end

  // Once nudged, a still-blocked sensor no longer holds the door.
  assign sensor_eff = doorSensor & ~nudge_q;
`else
  logic unused_nudge;
  assign unused_nudge = ^NUDGE_CYCLES;
  assign nudge_done   = 1'b0;
  assign sensor_eff   = doorSensor;
`endif

  // Counter sits at zero outside DWELL, so every entry starts a fresh dwell.
  cycle_timer #(.TC(DWELL_CYCLES), .CNT_W(CNT_W)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .en      (dst_q == D_DWELL),
    .restart (act),
    .done    (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (reset) dst_q <= D_IDLE;
    else       dst_q <= dst_d;
  end

  always_comb begin
    dst_d = dst_q;
    unique case (dst_q)
      D_IDLE: begin
        if (door)                     dst_d = D_DWELL;
        else if (doorOpenBtn && stopped) dst_d = D_FORCE;
      end
      D_FORCE: begin
        if (door)          dst_d = D_DWELL;
        else if (!stopped) dst_d = D_IDLE;
      end
      D_DWELL: begin
        if (!door)                                dst_d = D_IDLE;
        else if (nudge_done)                      dst_d = D_CLOSE;
        else if (act)                             dst_d = D_DWELL;
        else if (dwell_done || doorCloseBtn)      dst_d = D_CLOSE;
      end
      D_CLOSE: begin
        if (!door)           dst_d = D_IDLE;
        else if (nudge_done) dst_d = D_CLOSE;
        else if (act)        dst_d = D_DWELL;
      end
      default: dst_d = D_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered with it.
  always_comb begin
    dout_d            = '0;
    dout_d.open_door  = (dst_d == D_FORCE) | ((dst_d == D_DWELL) & act);
    dout_d.close_door = (dst_d == D_CLOSE);
    dout_d.dwell      = (dst_d == D_DWELL);
  end

  always_ff @(posedge clk) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign openDoor    = dout_q.open_door;
  assign closeDoor   = dout_q.close_door;
  assign dwellActive = dout_q.dwell;

endmodule

// File: tb/tb_elevator_sequencer.sv
// Directed and randomized bench for elevator_sequencer against a timestamp-based
// behavioural model of the call latch, door dwell rules and travel timer.
module tb_elevator_sequencer;
  import elevator_pkg::*;

  localparam int DW = 10;
  localparam int MV = 8;
  localparam int NG = 20;
`ifdef DOOR_NUDGE_EN
  localparam bit NUDGE_ON = 1'b1;
`else
  localparam bit NUDGE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] btn, resetButtons, calls;
  logic [2:0] state;
  logic       door, MoveCountEn, doorSensor, doorOpenBtn, doorCloseBtn;
  logic       openDoor, closeDoor, MoveCountDone, dwellActive;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_sequencer #(
    .DWELL_CYCLES (DW),
    .MOVE_CYCLES  (MV),
    .NUDGE_CYCLES (NG),
    .CNT_W        (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .resetButtons  (resetButtons),
    .state         (state),
    .door          (door),
    .MoveCountEn   (MoveCountEn),
    .doorSensor    (doorSensor),
    .doorOpenBtn   (doorOpenBtn),
    .doorCloseBtn  (doorCloseBtn),
    .calls         (calls),
    .openDoor      (openDoor),
    .closeDoor     (closeDoor),
    .MoveCountDone (MoveCountDone),
    .dwellActive   (dwellActive)
  );

  // Model: phase name, edge counter, edge of last dwell (re)start, run lengths.
  string      ph = "idle";
  int         edge_n = 0, start_n = 0, en_run = 0, srun = 0;
  bit         flag = 1'b0;
  logic [9:0] m_calls = '0;
  bit         e_open = 1'b0, e_close = 1'b0, e_dwell = 1'b0, e_done = 1'b0;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic chk_v(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    bit act, qual, nudge, stopped;
    act = 1'b0;
    edge_n++;
    if (reset) begin
      m_calls = '0; ph = "idle"; en_run = 0; srun = 0; flag = 1'b0; start_n = 0;
    end else begin
      m_calls = (m_calls | btn) & ~resetButtons;
      if (MoveCountEn) begin
        if (en_run < MV) en_run++;
      end else en_run = 0;
      qual    = (ph == "dwell" || ph == "close") && door && doorSensor && !flag;
      srun    = qual ? srun + 1 : 0;
      nudge   = NUDGE_ON && (srun == NG);
      act     = (doorSensor && !flag) || doorOpenBtn;
      stopped = (int'(state) % 2) == 0;
      if (ph == "idle") begin
        if (door) begin ph = "dwell"; start_n = edge_n; end
        else if (doorOpenBtn && stopped) ph = "force";
      end else if (ph == "force") begin
        if (door) begin ph = "dwell"; start_n = edge_n; end
        else if (!stopped) ph = "idle";
      end else if (ph == "dwell") begin
        if (!door) ph = "idle";
        else if (nudge) ph = "close";
        else if (act) start_n = edge_n;
        else if ((edge_n - start_n) == DW || doorCloseBtn) ph = "close";
      end else begin
        if (!door) ph = "idle";
        else if (!nudge && act) begin ph = "dwell"; start_n = edge_n; end
      end
      if (!door) flag = 1'b0;
      else if (nudge) flag = 1'b1;
    end
    e_open  = (ph == "force") || (ph == "dwell" && act);
    e_close = (ph == "close");
    e_dwell = (ph == "dwell");
    e_done  = (en_run >= MV);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_v("calls", calls, m_calls);
    chk_b("openDoor", openDoor, e_open);
    chk_b("closeDoor", closeDoor, e_close);
    chk_b("dwellActive", dwellActive, e_dwell);
    chk_b("MoveCountDone", MoveCountDone, e_done);
    chk_b("open_close_excl", openDoor & closeDoor, 1'b0);
  endtask

  initial begin
    logic [9:0] g1;
    g1 = '0;
    g1[G1_IDX] = 1'b1;
    reset = 1'b1; btn = '0; resetButtons = '0; state = 3'b010; door = 1'b0;
    MoveCountEn = 1'b0; doorSensor = 1'b0; doorOpenBtn = 1'b0; doorCloseBtn = 1'b0;
    tick(); tick();
    chk_v("rst_calls", calls, 10'b0);
    chk_b("rst_open", openDoor, 1'b0);
    chk_b("rst_close", closeDoor, 1'b0);
    chk_b("rst_done", MoveCountDone, 1'b0);
    chk_b("rst_dwell", dwellActive, 1'b0);
    reset = 1'b0;

    // Call latch
    btn = g1; tick(); chk_v("press", calls, 10'b0000001000);
    btn = '0; tick(); chk_v("hold", calls, 10'b0000001000);
    resetButtons = g1; tick(); chk_v("clear", calls, 10'b0);
    btn = g1; tick(); chk_v("press_and_clear", calls, 10'b0);
    resetButtons = '0; tick(); chk_v("relatch", calls, 10'b0000001000);
    btn = '0; resetButtons = g1; tick(); resetButtons = '0;

    // Dwell expiry and door fall
    door = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk_b($sformatf("dwell_close_%0d", i), closeDoor, i == 11);
      chk_b($sformatf("dwell_active_%0d", i), dwellActive, i < 11);
    end
    door = 1'b0; tick();
    chk_b("fall_close", closeDoor, 1'b0);
    chk_b("fall_dwell", dwellActive, 1'b0);

    // Reopen from close
    door = 1'b1;
    repeat (11) tick();
    chk_b("in_close", closeDoor, 1'b1);
    doorSensor = 1'b1; tick();
    chk_b("reopen_open", openDoor, 1'b1);
    chk_b("reopen_close", closeDoor, 1'b0);
    doorSensor = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_b($sformatf("redwell_close_%0d", i), closeDoor, i == 10);
    end
    door = 1'b0; tick();

    // Travel timer
    MoveCountEn = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk_b($sformatf("move_%0d", i), MoveCountDone, i >= 8);
    end
    MoveCountEn = 1'b0; tick(); chk_b("move_drop", MoveCountDone, 1'b0);
    MoveCountEn = 1'b1; repeat (4) tick();
    MoveCountEn = 1'b0; tick();
    MoveCountEn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_b($sformatf("move_restart_%0d", i), MoveCountDone, i == 8);
    end

    // Mid-operation reset
    door = 1'b1; btn = g1; repeat (3) tick();
    btn = '0; reset = 1'b1; tick();
    chk_b("midrst_dwell", dwellActive, 1'b0);
    chk_b("midrst_done", MoveCountDone, 1'b0);
    chk_v("midrst_calls", calls, 10'b0);
    reset = 1'b0; door = 1'b0; MoveCountEn = 1'b0; tick();

    // Door-open button only when stopped
    state = 3'b001; doorOpenBtn = 1'b1; tick(); tick();
    chk_b("btn_moving", openDoor, 1'b0);
    state = 3'b010; tick();
    chk_b("btn_stopped", openDoor, 1'b1);
    doorOpenBtn = 1'b0; state = 3'b011; tick();
    chk_b("force_abort", openDoor, 1'b0);

    // Sensor held continuously
    state = 3'b010; door = 1'b1; doorSensor = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
`ifdef DOOR_NUDGE_EN
      chk_b($sformatf("nudge_%0d", i), closeDoor, i >= 21);
`else
      chk_b($sformatf("blocked_%0d", i), closeDoor, 1'b0);
`endif
    end
    doorSensor = 1'b0; door = 1'b0; tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      btn          = ($urandom_range(0, 3) == 0) ? 10'(1 << $urandom_range(0, 9)) : 10'b0;
      resetButtons = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'b0;
      if ($urandom_range(0, 9) == 0)  state = 3'($urandom);
      if ($urandom_range(0, 24) == 0) door = ~door;
      MoveCountEn  = ($urandom_range(0, 11) != 0);
      doorSensor   = ($urandom_range(0, 11) == 0);
      doorOpenBtn  = ($urandom_range(0, 19) == 0);
      doorCloseBtn = ($urandom_range(0, 14) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_sequencer.md
Name: elevator_sequencer

Overview:
Timing and request front-end for floorControl. Latches the ten hall/car call buttons into held requests and clears them from floorControl's resetButtons. Generates openDoor/closeDoor from a door dwell FSM with obstruction-sensor and door-button handling. Generates MoveCountDone from a between-floor travel timer driven by MoveCountEn.

Parameters:
DWELL_CYCLES, 200_000_000, cycles the door stays open before a close request (min 2)
MOVE_CYCLES, 300_000_000, cycles of MoveCountEn before MoveCountDone (min 2)
NUDGE_CYCLES, 1_000_000_000, continuous sensor-blocked cycles before forced close (DOOR_NUDGE_EN only)
CNT_W, 32, width of all internal counters; must hold the largest *_CYCLES value

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
btn  in  10  raw call buttons {C1U,C2D,C2U,C3D,C3U,C4D,G1,G2,G3,G4}, already synchronised
resetButtons  in  10  clear strobes from floorControl, same bit order
state  in  3  floorControl state; a stopped state has state[0]==0
door  in  1  floorControl door output (1 = open)
MoveCountEn  in  1  travel timer enable from floorControl
doorSensor  in  1  obstruction sensor (1 = blocked)
doorOpenBtn  in  1  car door-open button
doorCloseBtn  in  1  car door-close button
calls  out  10  latched pending requests, to floorControl call inputs
openDoor  out  1  hold door open
closeDoor  out  1  request door close
MoveCountDone  out  1  travel complete
dwellActive  out  1  high while the dwell counter is running

Behaviour:
- Reset: calls=0, openDoor=0, closeDoor=0, MoveCountDone=0, dwellActive=0, door FSM=D_IDLE, all counters=0. Reset mid-operation aborts any dwell or travel immediately.
- Call latch, per bit i:
  - calls[i] <= (calls[i] | btn[i]) & ~resetButtons[i]; registered, so a press appears 1 cycle later.
  - When press and clear coincide, clear wins. A button held during a clear re-latches the cycle after the clear deasserts.
- Door FSM, all outputs registered:
  - D_IDLE: openDoor=0, closeDoor=0.
    - door==1 -> D_DWELL, counter=0.
    - Else doorOpenBtn & stopped -> D_FORCE.
  - D_FORCE: openDoor=1.
    - door==1 -> D_DWELL, counter=0.
    - Not stopped -> D_IDLE (button ignored while moving).
  - D_DWELL: dwellActive=1.
    - openDoor=1 while doorSensor | doorOpenBtn; otherwise 0.
    - doorSensor or doorOpenBtn restarts the counter at 0.
    - Counter == DWELL_CYCLES-1, or doorCloseBtn with no sensor/open button -> D_CLOSE.
  - D_CLOSE: closeDoor=1, openDoor=0.
    - doorSensor | doorOpenBtn -> D_DWELL, counter=0 (reopen; openDoor=1 next cycle).
    - door==0 -> D_IDLE.
  - door falling in any state -> D_IDLE.
  - openDoor and closeDoor are never high in the same cycle.
- Travel timer:
  - MoveCountEn==0: counter=0, MoveCountDone=0.
  - MoveCountEn==1: counter increments, saturating at MOVE_CYCLES-1.
  - MoveCountDone=1 from the cycle after the counter equals MOVE_CYCLES-1, held while MoveCountEn stays high.
  - MoveCountEn low for any single cycle restarts the timer.
- The travel timer is independent of the door FSM. The door FSM ignores MoveCountEn.

Optional Feature:
DOOR_NUDGE_EN
- Defined: a separate counter counts consecutive cycles of doorSensor==1 in D_DWELL/D_CLOSE.
  - Reaching NUDGE_CYCLES-1 forces D_CLOSE and sets an internal nudge flag.
  - While the flag is set, doorSensor no longer reopens or restarts dwell; doorOpenBtn still does.
  - Flag and counter clear on door==0 or reset.
- Undefined: no nudge logic; the sensor always reopens and restarts dwell. NUDGE_CYCLES is unused.

Decomposition:
- Shared package elevator_pkg holds:
  - door FSM state typedef (D_IDLE, D_FORCE, D_DWELL, D_CLOSE)
  - call-bit index constants (C1U_IDX..G4_IDX, matching resetButtons order)
  - the "stopped" test on state
- One natural sub-module: cycle_timer (enable, restart, terminal-count parameter, done output).
  - Instantiated for dwell, travel, and nudge (nudge instance under DOOR_NUDGE_EN).

Test Plan:
1. btn=10'b0000001000 for 1 cycle -> calls=10'b0000001000 from cycle+1. resetButtons=10'b0000001000 for 1 cycle -> calls=0. Simultaneous btn and clear on the same bit -> bit stays 0.
2. DWELL_CYCLES=10, door rises, no inputs -> closeDoor=1 exactly 10 cycles later. door falls -> closeDoor=0 next cycle, FSM in D_IDLE.
3. In D_CLOSE, doorSensor=1 for 1 cycle -> openDoor=1 next cycle, closeDoor=0, dwell restarts; closeDoor reasserts 10 cycles after the sensor drops.
4. MOVE_CYCLES=8, MoveCountEn high -> MoveCountDone rises 8 cycles after enable and stays high. Enable dropped at cycle 5 then raised -> done is 8 cycles after the re-raise.
5. state=3'b001, doorOpenBtn=1 -> openDoor stays 0. state=3'b010, door=0, doorOpenBtn=1 -> openDoor=1 next cycle.
6. With DOOR_NUDGE_EN and NUDGE_CYCLES=20, doorSensor held high -> closeDoor=1 after 20 cycles, and the still-held sensor does not reopen. Without the macro -> closeDoor never asserts.
